// File: rtl/key_debounce_repeat_if.sv
// Key front-end bundle: raw active-low keys and repeat enables in,
// debounced level and single-cycle event pulses out.
interface key_debounce_repeat_if #(
  parameter int unsigned N_KEYS = 3
) ();
  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] repeat_en;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_long;
  logic [N_KEYS-1:0] key_repeat;

  modport master (
    output key_n, repeat_en,
    input  key_level, key_press, key_release, key_long, key_repeat
  );

  modport slave (
    input  key_n, repeat_en,
    output key_level, key_press, key_release, key_long, key_repeat
  );
endinterface

// File: rtl/key_debounce_repeat.sv
// N-channel key front end: 2-flop sync, tick-based debounce, press/release events,
// long-press detection and optional auto-repeat. One prescaled tick shared by all keys.
module key_debounce_repeat #(
  parameter int unsigned N_KEYS      = 3,
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned REPEAT_MS   = 100,
  parameter int unsigned SIMULATION  = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  key_debounce_repeat_if.slave keys
);

  localparam int unsigned DIV    = (SIMULATION != 0) ? CLK_FREQ_HZ / 1000000
                                                     : CLK_FREQ_HZ / 1000;
  localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_MS);
  localparam int unsigned HCNT_W = $clog2(LONG_MS);
  localparam int unsigned RCNT_W = (REPEAT_MS > 1) ? $clog2(REPEAT_MS) : 1;

  localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_MS - 1);
  localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(LONG_MS - 1);
  localparam logic [RCNT_W-1:0] RCNT_MAX = RCNT_W'(REPEAT_MS - 1);

  typedef enum logic [2:0] {
    StIdle, StDbPress, StPressed, StRepeat, StHeld, StDbRel
  } state_e;

  logic [DIV_W-1:0] presc_q;
  logic             tick;

  assign tick = (presc_q == DIV_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + DIV_W'(1);
    end
  end

  logic [N_KEYS-1:0] sync1_q, sync2_q, p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= keys.key_n;
      sync2_q <= sync1_q;
    end
  end

  assign p = ~sync2_q;

  logic [N_KEYS-1:0] level_v, press_v, release_v, long_v, repeat_v;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              level_q, level_d;
    logic              press_q, press_d, release_q, release_d;
    logic              long_q, long_d, repeat_q, repeat_d;

    // A change of p always takes priority; the tick in that cycle is dropped.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hcnt_d    = hcnt_q;
      rcnt_d    = rcnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      case (state_q)
        StIdle: begin
          if (p[i]) begin
            state_d = StDbPress;
            cnt_d   = '0;
          end
        end
        StDbPress: begin
          if (!p[i]) begin
            state_d = StIdle;
          end else if (tick) begin
            if (cnt_q == CNT_MAX) begin
              state_d = StPressed;
              press_d = 1'b1;
              level_d = 1'b1;
              hcnt_d  = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        StPressed: begin
          if (!p[i]) begin
            state_d = StDbRel;
            cnt_d   = '0;
          end else if (tick) begin
            if (hcnt_q == HCNT_MAX) begin
              long_d = 1'b1;
              if (keys.repeat_en[i]) begin
                repeat_d = 1'b1;
                rcnt_d   = '0;
                state_d  = StRepeat;
              end else begin
                state_d = StHeld;
              end
            end else begin
              hcnt_d = hcnt_q + HCNT_W'(1);
            end
          end
        end
        StRepeat: begin
          if (!p[i]) begin
            state_d = StDbRel;
            cnt_d   = '0;
          end else if (!keys.repeat_en[i]) begin
            state_d = StHeld;
          end else if (tick) begin
            if (rcnt_q == RCNT_MAX) begin
              repeat_d = 1'b1;
              rcnt_d   = '0;
            end else begin
              rcnt_d = rcnt_q + RCNT_W'(1);
            end
          end
        end
        StHeld: begin
          if (!p[i]) begin
            state_d = StDbRel;
            cnt_d   = '0;
          end
        end
        StDbRel: begin
          // A bounce back to pressed parks in StHeld: level stays high, no new press.
          if (p[i]) begin
            state_d = StHeld;
          end else if (tick) begin
            if (cnt_q == CNT_MAX) begin
              state_d   = StIdle;
              release_d = 1'b1;
              level_d   = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= StIdle;
        cnt_q     <= '0;
        hcnt_q    <= '0;
        rcnt_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        hcnt_q    <= hcnt_d;
        rcnt_q    <= rcnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
        repeat_q  <= repeat_d;
      end
    end

    assign level_v[i]   = level_q;
    assign press_v[i]   = press_q;
    assign release_v[i] = release_q;
    assign long_v[i]    = long_q;
    assign repeat_v[i]  = repeat_q;
  end

  assign keys.key_level   = level_v;
  assign keys.key_press   = press_v;
  assign keys.key_release = release_v;
  assign keys.key_long    = long_v;
  assign keys.key_repeat  = repeat_v;

endmodule

// File: doc/key_debounce_repeat.md
Name: key_debounce_repeat

Overview:
- Parametrised N-channel key front end. It replaces the per-key debounce instances between the raw active-low push-buttons and the clock/alarm controller.
- Each channel synchronises and debounces its key, then emits single-cycle press and release events.
- Each channel also detects a long press and, when enabled, auto-repeats. This lets hour/minute adjustment step continuously while a key is held.
- All channels share one prescaled millisecond tick.

Parameters:
- N_KEYS, 3, number of independent key channels (>=1).
- CLK_FREQ_HZ, 50000000, input clock frequency.
- DEBOUNCE_MS, 20, stable-time requirement in ticks (>=2).
- LONG_MS, 1000, hold time in ticks before a long-press event (>DEBOUNCE_MS).
- REPEAT_MS, 100, auto-repeat period in ticks (>=1).
- SIMULATION, 0, when 1 the tick period is 1 us instead of 1 ms.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- key_n, input, N_KEYS, raw keys; active-low, asynchronous, bouncy.
- repeat_en, input, N_KEYS, per-channel auto-repeat enable, synchronous.
- key_level, output, N_KEYS, debounced pressed state (1 = pressed).
- key_press, output, N_KEYS, one-cycle pulse on debounced press.
- key_release, output, N_KEYS, one-cycle pulse on debounced release.
- key_long, output, N_KEYS, one-cycle pulse when the hold reaches LONG_MS.
- key_repeat, output, N_KEYS, one-cycle auto-repeat pulses.

Behaviour:
- Reset:
  - All outputs are 0.
  - Synchroniser flops are 1 (released).
  - All FSMs are in IDLE; all counters are 0.
  - The tick prescaler is 0.
  - Reset asserted mid-operation aborts everything immediately. No release pulse is emitted.
- Tick:
  - DIV = CLK_FREQ_HZ/1000, or CLK_FREQ_HZ/1000000 when SIMULATION=1.
  - The prescaler counts 0..DIV-1 and asserts tick for one cycle at DIV-1.
  - The tick is free-running and shared by all channels.
- Synchroniser: 2-flop per key; p = ~sync (1 = pressed). Input-to-p latency is 2 cycles.
- Per-channel FSM. cnt is the debounce counter, hcnt the hold counter, rcnt the repeat counter.
  - IDLE: p=1 -> DB_PRESS with cnt=0.
  - DB_PRESS:
    - p=0 -> IDLE with no event.
    - Otherwise, on tick, cnt++.
    - On the tick where cnt==DEBOUNCE_MS-1 -> PRESSED. Pulse key_press, set key_level=1, hcnt=0.
  - PRESSED:
    - p=0 -> DB_REL with cnt=0.
    - Otherwise, on tick, hcnt++.
    - On the tick where hcnt==LONG_MS-1, pulse key_long. If repeat_en=1, also pulse key_repeat in the same cycle and go to REPEAT with rcnt=0. Otherwise go to HELD.
  - REPEAT:
    - p=0 -> DB_REL.
    - repeat_en=0 -> HELD.
    - Otherwise, on tick, rcnt++. When rcnt==REPEAT_MS-1, pulse key_repeat and set rcnt=0.
  - HELD:
    - p=0 -> DB_REL.
    - Otherwise no events. Re-asserting repeat_en does not restart repeats.
  - DB_REL:
    - p=1 (bounce) -> HELD; key_level stays 1 and no new press is emitted.
    - Otherwise, on tick, cnt++. On cnt==DEBOUNCE_MS-1 -> IDLE. Pulse key_release and set key_level=0.
- Priority when the same cycle has a p change and a tick: the p change wins and the tick is ignored for that channel.
- Timing:
  - Debounce latency is between DEBOUNCE_MS-1 and DEBOUNCE_MS ticks of stable input, plus 2-3 cycles.
  - key_long fires LONG_MS ticks (±1) after key_press.
- All events are registered. Outputs change only on clk rise.
- Exactly one event pulse per transition, never repeated.
- Channels are fully independent. Simultaneous presses on any subset behave identically to single presses.
- Counters are sized $clog2 of their maximum. They never wrap beyond their terminal value.

Test Plan (SIMULATION=1, 50 MHz, tick = 1 us, defaults otherwise):
- Clean press: key_n[1] low for 21 us then released -> exactly 1 key_press[1] and 1 key_release[1] (press is a one-cycle pulse). key_level[1] is high for about 20 us. No key_long. Other channels stay silent.
- Bounce: key_n[0] toggles every 3 us for 15 us, then is held low for 25 us -> exactly one key_press[0], 19-21 us after the final falling edge. Release bounce of 5 us glitches -> one key_release[0].
- Long press with repeat: repeat_en[1]=1, key_n[1] held 1250 us -> key_press at about 20 us, then key_long plus the first key_repeat at about 1020 us, then key_repeat at about 1120 and 1220 us. Total key_repeat count is 3.
- Long press without repeat: repeat_en=0, 1250 us hold -> one key_long, zero key_repeat. Dropping repeat_en mid-REPEAT stops pulses within 1 cycle.
- Simultaneous: all three keys pressed on the same cycle for 21 us -> all key_press bits assert in the same cycle, and all key_release bits assert together.
- Reset mid-hold: rst_n pulsed low at 500 us of a hold -> all outputs 0 immediately. With the key still held after reset, a fresh key_press follows about 20 us later. No release pulse is emitted on reset.
